// File: rtl/bcd_convert_sequencer_pkg.sv
// Shared definitions for the BCD conversion sequencer: widths, FSM state
// encoding, converter field-select codes and the packed BCD digit pair.
// Optional feature macro: BCD_SEQ_SECONDS_EN adds the seconds conversion state.
package bcd_seq_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BIN_W   = 6;
  localparam int unsigned HRS_W   = 5;
  localparam int unsigned FIELD_W = 2 * BCD_W;
  localparam int unsigned SEL_W   = 2;

  // One conversion state per displayed field.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONV_HRS = 2'd1,
`ifdef BCD_SEQ_SECONDS_EN
    ST_CONV_MIN = 2'd2,
    ST_CONV_SEC = 2'd3
`else
    ST_CONV_MIN = 2'd2
`endif
  } state_e;

  // Field-select codes for the shared converter input mux.
  localparam logic [SEL_W-1:0] SEL_HRS = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MIN = 2'd1;
  localparam logic [SEL_W-1:0] SEL_SEC = 2'd2;

  // Two BCD digits of one field, tens in the upper nibble.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;

  // Which field the converter works on in a given state.
  function automatic logic [SEL_W-1:0] field_of_state(input state_e s);
    logic [SEL_W-1:0] sel;
    sel = SEL_HRS;
    case (s)
      ST_CONV_MIN: sel = SEL_MIN;
`ifdef BCD_SEQ_SECONDS_EN
      ST_CONV_SEC: sel = SEL_SEC;
`endif
      default:     sel = SEL_HRS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bcd_convert_sequencer_if.sv
// Bus between the sequencer and its shared binary-to-BCD converter.
//   bin : 6-bit binary value presented to the converter
//   bcd : converter result as a tens/ones digit pair
// Modports: master (sequencer side), slave (converter side).
interface bcd_conv_if;
  import bcd_seq_pkg::*;

  logic [BIN_W-1:0] bin;
  bcd_pair_t        bcd;

  modport master (output bin, input bcd);
  modport slave  (input bin, output bcd);
endinterface

// File: rtl/bcd_convert_sequencer_bin_to_bcd.sv
// Combinational 6-bit binary to two-digit BCD converter (0..63 -> 00..63).
// Ports: conv (bcd_conv_if.slave) -- bin in, bcd digit pair out.
module bin_to_bcd
  import bcd_seq_pkg::*;
(
  bcd_conv_if.slave conv
);

  always_comb begin
    conv.bcd.tens = BCD_W'(conv.bin / BIN_W'(10));
    conv.bcd.ones = BCD_W'(conv.bin % BIN_W'(10));
  end

endmodule

// File: rtl/bcd_convert_sequencer.sv
// Converts a binary hh/mm/ss time snapshot to BCD, one field per cycle,
// through a single shared converter, then publishes all fields at once.
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_start                  : conversion request (accepted only when idle)
//   i_hours/minutes/seconds  : binary time fields
//   o_busy                   : sequence in progress
//   o_done                   : one-cycle pulse when new BCD outputs appear
//   o_hours/minutes/seconds_bcd : {tens, ones} results
// Macro BCD_SEQ_SECONDS_EN: when undefined, seconds are not converted and
// o_seconds_bcd is tied to zero.
module bcd_convert_sequencer
  import bcd_seq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [HRS_W-1:0]   i_hours,
  input  logic [BIN_W-1:0]   i_minutes,
  input  logic [BIN_W-1:0]   i_seconds,
  output logic               o_busy,
  output logic               o_done,
  output logic [FIELD_W-1:0] o_hours_bcd,
  output logic [FIELD_W-1:0] o_minutes_bcd,
  output logic [FIELD_W-1:0] o_seconds_bcd
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [HRS_W-1:0] hrs_snap_q;
  logic [BIN_W-1:0] min_snap_q;
  bcd_pair_t        hrs_sh_q;
  bcd_pair_t        min_sh_q;
  bcd_pair_t        hrs_out_q;
  bcd_pair_t        min_out_q;
  bcd_pair_t        conv_bcd;
  logic [BIN_W-1:0] sec_bin;

  bcd_conv_if conv_if ();

  bin_to_bcd u_bin_to_bcd (
    .conv (conv_if)
  );

`ifdef BCD_SEQ_SECONDS_EN
  logic [BIN_W-1:0] sec_snap_q;
  bcd_pair_t        sec_sh_q;
  bcd_pair_t        sec_out_q;

  assign sec_bin       = sec_snap_q;
  assign o_seconds_bcd = sec_out_q;
`else
  logic unused_seconds;

  assign unused_seconds = ^i_seconds;
  assign sec_bin        = '0;
  assign o_seconds_bcd  = '0;
`endif

  // Shared converter input mux; hours are zero-extended to the converter width.
  always_comb begin
    conv_if.bin = BIN_W'(hrs_snap_q);
    case (field_of_state(state_q))
      SEL_MIN: conv_if.bin = min_snap_q;
      SEL_SEC: conv_if.bin = sec_bin;
      default: conv_if.bin = BIN_W'(hrs_snap_q);
    endcase
  end

  assign conv_bcd = conv_if.bcd;

  // Sequencer FSM: snapshot, convert field by field, publish atomically.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hrs_snap_q <= '0;
      min_snap_q <= '0;
      hrs_sh_q   <= '0;
      min_sh_q   <= '0;
      hrs_out_q  <= '0;
      min_out_q  <= '0;
`ifdef BCD_SEQ_SECONDS_EN
      sec_snap_q <= '0;
      sec_sh_q   <= '0;
      sec_out_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            hrs_snap_q <= i_hours;
            min_snap_q <= i_minutes;
`ifdef BCD_SEQ_SECONDS_EN
            sec_snap_q <= i_seconds;
`endif
            busy_q     <= 1'b1;
            state_q    <= ST_CONV_HRS;
          end
        end
        ST_CONV_HRS: begin
          hrs_sh_q <= conv_bcd;
          state_q  <= ST_CONV_MIN;
        end
`ifdef BCD_SEQ_SECONDS_EN
        ST_CONV_MIN: begin
          min_sh_q <= conv_bcd;
          state_q  <= ST_CONV_SEC;
        end
        ST_CONV_SEC: begin
          sec_sh_q  <= conv_bcd;
          hrs_out_q <= hrs_sh_q;
          min_out_q <= min_sh_q;
          sec_out_q <= conv_bcd;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
`else
        ST_CONV_MIN: begin
          min_sh_q  <= conv_bcd;
          hrs_out_q <= hrs_sh_q;
          min_out_q <= conv_bcd;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_hours_bcd   = hrs_out_q;
  assign o_minutes_bcd = min_out_q;

endmodule

// File: doc/bcd_convert_sequencer.md
BCD_CONVERT_SEQUENCER -- requirements
Module: bcd_convert_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port i_start, input, 1, conversion request; sampled only in IDLE.
REQ-004 SHALL have port i_hours, input, 5, binary hours (0-31 accepted; 0-23 nominal).
REQ-005 SHALL have port i_minutes, input, 6, binary minutes (0-63 accepted).
REQ-006 SHALL have port i_seconds, input, 6, binary seconds (0-63 accepted).
REQ-007 SHALL have port o_busy, output, 1, high while a conversion sequence is in progress.
REQ-008 SHALL have port o_done, output, 1, single-cycle pulse marking new results on the BCD outputs.
REQ-009 SHALL have port o_hours_bcd, output, 8, {tens[7:4], ones[3:0]} of hours.
REQ-010 SHALL have port o_minutes_bcd, output, 8, {tens, ones} of minutes.
REQ-011 SHALL have port o_seconds_bcd, output, 8, {tens, ones} of seconds.

Function
REQ-012 SHALL time-share one binary-to-BCD converter (6-bit in, two 4-bit digits out, combinational) across the three fields via a 6-bit input mux; hours zero-extended.
REQ-013 SHALL implement states IDLE, CONV_HRS, CONV_MIN, CONV_SEC; IDLE->CONV_HRS on i_start; CONV_HRS->CONV_MIN->CONV_SEC->IDLE unconditionally, one cycle each.
REQ-014 SHALL snapshot i_hours/i_minutes/i_seconds into internal registers on the edge accepting i_start; input changes during the sequence do not affect results.
REQ-015 SHALL latch converter output into a per-field shadow register at the end of each CONV_* cycle.
REQ-016 SHALL update all three BCD outputs simultaneously on the edge leaving the final CONV state (no torn display values); outputs otherwise hold.
REQ-017 Latency: i_start high in cycle 0 -> o_busy high cycles 1-3 -> o_done high and new outputs visible in cycle 4, o_busy low in cycle 4.
REQ-018 o_busy SHALL equal (state != IDLE); o_done SHALL be registered, high exactly one cycle per completed sequence.
REQ-019 i_start while busy SHALL be ignored (not queued); i_start in the o_done cycle SHALL be accepted (back-to-back period 4 cycles).
REQ-020 Out-of-nominal values SHALL convert arithmetically (hours 31 -> 8'h31, minutes 63 -> 8'h63); no saturation or flagging.

Reset
REQ-021 i_reset SHALL force IDLE, o_busy=0, o_done=0, all BCD outputs 8'h00, shadows and snapshots cleared.
REQ-022 Reset asserted mid-sequence SHALL abort it; no o_done, outputs return to 8'h00; reset takes priority over i_start.

Configuration
REQ-023 Macro BCD_SEQ_SECONDS_EN defined: behaviour as above, 3 conversion states.
REQ-024 Macro undefined: CONV_SEC and seconds snapshot/shadow omitted; CONV_MIN->IDLE; o_seconds_bcd tied 8'h00; o_done in cycle 3, o_busy cycles 1-2; i_seconds unused.

Structure
REQ-025 Shared package bcd_seq_pkg SHALL hold state encoding constants, field-select constants (HRS/MIN/SEC), and BCD width constant (4).
REQ-026 SHALL instantiate exactly one bin_to_bcd sub-module as the shared converter; no other sub-modules.

Verification
REQ-027 Reset then idle: after reset -> all outputs 8'h00, o_busy=0, o_done never pulses.
REQ-028 Start with 23/59/58 -> o_busy cycles 1-3, cycle 4 o_done=1 with 8'h23/8'h59/8'h58.
REQ-029 Start with 12/34/56, change inputs to 0/0/0 in cycle 1 -> results 8'h12/8'h34/8'h56; start pulses in cycles 1-3 ignored, one o_done only.
REQ-030 Back-to-back: start in cycle 0 and in o_done cycle 4 with 9/10/59 -> second o_done cycle 8, outputs 8'h09/8'h10/8'h59.
REQ-031 Reset in cycle 2 of sequence -> no o_done, outputs 8'h00, IDLE next cycle; edge values 31/63/0 -> 8'h31/8'h63/8'h00.
REQ-032 Build without BCD_SEQ_SECONDS_EN, start with 7/45/30 -> o_done cycle 3, 8'h07/8'h45, o_seconds_bcd=8'h00.
